fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid bus.
- Buffers in-order responses, with their PCs, in a small FIFO.
- Presents one instruction per cycle to the decoder over a valid/ready handshake, and handles redirects (branch/jump/trap) by flushing wrong-path state.

---
 rtl/fetch_unit.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Owns the program counter and issues word fetches over a req/gnt/rvalid
// bus. In-order responses are buffered with their PCs in a small FIFO and
// handed to the decoder over a valid/ready handshake. A redirect flushes the
// buffer and waits (DRAIN) until every request already on the bus has
// returned, so no wrong-path word ever reaches the decoder.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   -> a response arriving while the buffer is empty is presented to
//                the decoder in the same cycle (0-cycle latency)
//   undefined -> every response goes through the buffer (1-cycle latency)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   imem_req_o     fetch request valid
//   imem_addr_o    word-aligned fetch address (the current PC)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (responses return in request order)
//   imem_rdata_i   response instruction word
//   redirect_i     one-cycle redirect pulse (branch/jump/trap)
//   redirect_pc_i  redirect target (low two bits ignored)
//   inst_valid_o   instruction available to the decoder
//   inst_o         instruction word
//   inst_pc_o      PC of inst_o
//   inst_ready_i   decoder accepts inst_o this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        inst_mem_q [FIFO_DEPTH];
    logic [31:0]        inst_mem_d [FIFO_DEPTH];
    logic [31:0]        pc_mem_q   [FIFO_DEPTH];
    logic [31:0]        pc_mem_d   [FIFO_DEPTH];

    logic [SUM_W-1:0]   credit_sum_s;
    logic               req_s;
    logic               accept_s;
    logic               rsp_s;
    logic [31:0]        rsp_pc_s;
    logic               fifo_nonempty_s;
    logic               bypass_s;
    logic               push_s;
    logic               pop_s;

    // Buffered entries plus requests on the bus may never exceed the buffer,
    // so every response is guaranteed a slot.
    assign credit_sum_s = SUM_W'(count_q) + SUM_W'(outst_q);
    assign req_s        = (state_q == ST_RUN) && (credit_sum_s < DEPTH_L);
    assign accept_s     = req_s && imem_gnt_i;
    // A response with nothing outstanding (e.g. left over from before a reset)
    // is not ours and is ignored.
    assign rsp_s        = imem_rvalid_i && (outst_q != {CNT_W{1'b0}});
    // In RUN the outstanding requests are the consecutive words just below
    // pc_q, so the PC of the oldest one is recovered arithmetically; this
    // plays the role of a PC shadow queue without storing it.
    assign rsp_pc_s     = pc_q - (32'(outst_q) << 2);

    assign fifo_nonempty_s = (state_q == ST_RUN) && (count_q != {CNT_W{1'b0}});

`ifdef FETCH_BYPASS_EN
    assign bypass_s = (state_q == ST_RUN) && (count_q == {CNT_W{1'b0}}) && rsp_s && !redirect_i;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed word taken by the decoder this cycle is never stored.
    assign push_s = (state_q == ST_RUN) && rsp_s && !redirect_i && !(bypass_s && inst_ready_i);
    assign pop_s  = fifo_nonempty_s && inst_ready_i;

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_q;

    // Decoder-facing outputs: buffer head, or the live response when bypassing
    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = 32'h0000_0000;
        inst_pc_o    = 32'h0000_0000;
        if (bypass_s) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            inst_pc_o    = rsp_pc_s;
        end else if (fifo_nonempty_s) begin
            inst_valid_o = 1'b1;
            inst_o       = inst_mem_q[rd_ptr_q];
            inst_pc_o    = pc_mem_q[rd_ptr_q];
        end else begin
            inst_valid_o = 1'b0;
        end
    end

    // Next-state logic: PC, outstanding count, buffer and RUN/DRAIN control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outst_d    = outst_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;

        // Every accepted response retires a request, dropped or not.
        outst_d = outst_q + CNT_W'(accept_s) - CNT_W'(rsp_s);

        if (redirect_i) begin
            pc_d = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (accept_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    // Flush wrong-path entries; any same-cycle response is
                    // dropped, and a same-cycle pop simply took the head.
                    count_d  = {CNT_W{1'b0}};
                    rd_ptr_d = {PTR_W{1'b0}};
                    wr_ptr_d = {PTR_W{1'b0}};
                    state_d  = (outst_d == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
                end else begin
                    if (push_s) begin
                        inst_mem_d[wr_ptr_q] = imem_rdata_i;
                        pc_mem_d[wr_ptr_q]   = rsp_pc_s;
                        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Responses for wrong-path requests are discarded; a redirect
                // here only reloads the PC.
                state_d = (outst_d == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            pc_q     <= BOOT_ADDR;
            outst_q  <= {CNT_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]   <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    fetch_unit_checker #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_checker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .count_i (count_q)
    );

endmodule

// ---------------------------------------------------------------------------
// fetch_unit_checker -- run-time checks for fetch_unit.
//   push_i/pop_i  buffer write/read strobes
//   count_i       current buffer occupancy
// ---------------------------------------------------------------------------
module fetch_unit_checker #(
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CNT_W-1:0] count_i
);

    // A write into a full buffer without a simultaneous read is an overflow
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_i && !pop_i && (count_i == CNT_W'(FIFO_DEPTH))));
        end
    end

endmodule
